// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instructions, renames, allocates ROB
// entries and issues resolved operands to the reservation station.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   dec_*   : decoder beat in, dec_ready_out back-pressure
//   rf_*    : regfile lookup of head sources, rename write of head rd
//   rob_*   : ROB allocation, ready-query of pending source tags
//   cdb_*   : common data bus snoop for same-cycle wakeup
//   flush_in: mispredict flush, empties the queue
//   rs_*    : registered issue bundle to the reservation station
module dispatch_queue #(
  parameter int ROB_W  = 4,
  parameter int DEPTH  = 4,
  parameter int OPC_W  = 6,
  parameter int TYPE_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,

  input  logic              dec_valid_in,
  output logic              dec_ready_out,
  input  logic [TYPE_W-1:0] dec_type_in,
  input  logic [OPC_W-1:0]  dec_op_in,
  input  logic [4:0]        dec_rs1_in,
  input  logic [4:0]        dec_rs2_in,
  input  logic [4:0]        dec_rd_in,
  input  logic [31:0]       dec_imm_in,

  output logic [4:0]        rf_rs1_out,
  output logic [4:0]        rf_rs2_out,
  input  logic              rf_rs1_busy_in,
  input  logic              rf_rs2_busy_in,
  input  logic [31:0]       rf_rs1_val_in,
  input  logic [31:0]       rf_rs2_val_in,
  input  logic [ROB_W-1:0]  rf_rs1_rob_in,
  input  logic [ROB_W-1:0]  rf_rs2_rob_in,
  output logic              rf_rename_out,
  output logic [4:0]        rf_rd_out,
  output logic [ROB_W-1:0]  rf_rob_out,

  input  logic              rob_ready_in,
  input  logic [ROB_W-1:0]  rob_tag_in,
  output logic              rob_alloc_out,
  output logic [TYPE_W-1:0] rob_type_out,
  output logic [31:0]       rob_dest_out,
  output logic [ROB_W-1:0]  rob_q1_out,
  output logic [ROB_W-1:0]  rob_q2_out,
  input  logic              rob_q1_rdy_in,
  input  logic              rob_q2_rdy_in,
  input  logic [31:0]       rob_q1_val_in,
  input  logic [31:0]       rob_q2_val_in,

  input  logic              cdb_valid_in,
  input  logic [ROB_W-1:0]  cdb_tag_in,
  input  logic [31:0]       cdb_val_in,

  input  logic              flush_in,
  input  logic              rs_ready_in,

  output logic              rs_valid_out,
  output logic [OPC_W-1:0]  rs_op_out,
  output logic [31:0]       rs_vj_out,
  output logic [31:0]       rs_vk_out,
  output logic [ROB_W-1:0]  rs_qj_out,
  output logic [ROB_W-1:0]  rs_qk_out,
  output logic              rs_qj_busy_out,
  output logic              rs_qk_busy_out,
  output logic [31:0]       rs_a_out,
  output logic [ROB_W-1:0]  rs_tag_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [OPC_W-1:0]  op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
  } entry_t;

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] q;
    logic [31:0]      v;
  } opnd_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  entry_t            head_e;
  entry_t            dec_e;
  logic              enq;
  logic              fire;
  opnd_t             op1;
  opnd_t             op2;

  // Priority: x0, regfile, ROB forward, CDB snoop, else still pending.
  function automatic opnd_t resolve(
    input logic [4:0]       idx,
    input logic             busy,
    input logic [31:0]      val,
    input logic [ROB_W-1:0] tag,
    input logic             qrdy,
    input logic [31:0]      qval,
    input logic             cv,
    input logic [ROB_W-1:0] ctag,
    input logic [31:0]      cval
  );
    opnd_t r;
    r = '0;
    if (idx == 5'd0) begin
      r = '0;
    end else if (!busy) begin
      r.v = val;
    end else if (qrdy) begin
      r.v = qval;
    end else if (cv && (ctag == tag)) begin
      r.v = cval;
    end else begin
      r.busy = 1'b1;
      r.q    = tag;
    end
    return r;
  endfunction

  assign head_e = mem_q[head_q];

  always_comb begin
    dec_e     = '0;
    dec_e.typ = dec_type_in;
    dec_e.op  = dec_op_in;
    dec_e.rs1 = dec_rs1_in;
    dec_e.rs2 = dec_rs2_in;
    dec_e.rd  = dec_rd_in;
    dec_e.imm = dec_imm_in;
  end

  assign dec_ready_out = (count_q != FULL);

  assign enq  = dec_valid_in & dec_ready_out
              & rdy_in & ~flush_in;
  assign fire = (count_q != '0) & rob_ready_in
              & rs_ready_in & rdy_in & ~flush_in;

  assign rf_rs1_out    = head_e.rs1;
  assign rf_rs2_out    = head_e.rs2;
  assign rf_rename_out = fire & (head_e.rd != 5'd0);
  assign rf_rd_out     = head_e.rd;
  assign rf_rob_out    = rob_tag_in;
  assign rob_alloc_out = fire;
  assign rob_type_out  = head_e.typ;
  assign rob_dest_out  = {27'd0, head_e.rd};
  assign rob_q1_out    = rf_rs1_rob_in;
  assign rob_q2_out    = rf_rs2_rob_in;

  always_comb begin
    op1 = resolve(head_e.rs1, rf_rs1_busy_in,
                  rf_rs1_val_in, rf_rs1_rob_in,
                  rob_q1_rdy_in, rob_q1_val_in,
                  cdb_valid_in, cdb_tag_in, cdb_val_in);
    op2 = resolve(head_e.rs2, rf_rs2_busy_in,
                  rf_rs2_val_in, rf_rs2_rob_in,
                  rob_q2_rdy_in, rob_q2_val_in,
                  cdb_valid_in, cdb_tag_in, cdb_val_in);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (fire) head_d = head_q + PTR_W'(1);
    unique case ({enq, fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq) begin
      mem_q[tail_q] <= dec_e;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      rs_valid_out   <= 1'b0;
      rs_op_out      <= '0;
      rs_vj_out      <= '0;
      rs_vk_out      <= '0;
      rs_qj_out      <= '0;
      rs_qk_out      <= '0;
      rs_qj_busy_out <= 1'b0;
      rs_qk_busy_out <= 1'b0;
      rs_a_out       <= '0;
      rs_tag_out     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
        rs_valid_out <= 1'b0;
      end else begin
        head_q       <= head_d;
        tail_q       <= tail_d;
        count_q      <= count_d;
        // Issue is a one-cycle pulse; data fields hold between issues.
        rs_valid_out <= fire;
        if (fire) begin
          rs_op_out      <= head_e.op;
          rs_vj_out      <= op1.v;
          rs_vk_out      <= op2.v;
          rs_qj_out      <= op1.q;
          rs_qk_out      <= op2.q;
          rs_qj_busy_out <= op1.busy;
          rs_qk_busy_out <= op2.busy;
          rs_a_out       <= head_e.imm;
          rs_tag_out     <= rob_tag_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue.
// Drives beats #1 after the rising edge and checks before the next one.
module tb_dispatch_queue;

  localparam int ROB_W = 4;
  localparam int OPC_W = 6;
  localparam int TYPE_W = 3;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic dec_valid_in;
  logic dec_ready_out;
  logic [TYPE_W-1:0] dec_type_in;
  logic [OPC_W-1:0] dec_op_in;
  logic [4:0] dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic [31:0] dec_imm_in;
  logic [4:0] rf_rs1_out, rf_rs2_out;
  logic rf_rs1_busy_in, rf_rs2_busy_in;
  logic [31:0] rf_rs1_val_in, rf_rs2_val_in;
  logic [ROB_W-1:0] rf_rs1_rob_in, rf_rs2_rob_in;
  logic rf_rename_out;
  logic [4:0] rf_rd_out;
  logic [ROB_W-1:0] rf_rob_out;
  logic rob_ready_in;
  logic [ROB_W-1:0] rob_tag_in;
  logic rob_alloc_out;
  logic [TYPE_W-1:0] rob_type_out;
  logic [31:0] rob_dest_out;
  logic [ROB_W-1:0] rob_q1_out, rob_q2_out;
  logic rob_q1_rdy_in, rob_q2_rdy_in;
  logic [31:0] rob_q1_val_in, rob_q2_val_in;
  logic cdb_valid_in;
  logic [ROB_W-1:0] cdb_tag_in;
  logic [31:0] cdb_val_in;
  logic flush_in;
  logic rs_ready_in;
  logic rs_valid_out;
  logic [OPC_W-1:0] rs_op_out;
  logic [31:0] rs_vj_out, rs_vk_out;
  logic [ROB_W-1:0] rs_qj_out, rs_qk_out;
  logic rs_qj_busy_out, rs_qk_busy_out;
  logic [31:0] rs_a_out;
  logic [ROB_W-1:0] rs_tag_out;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  dispatch_queue #(
    .ROB_W(ROB_W), .DEPTH(4),
    .OPC_W(OPC_W), .TYPE_W(TYPE_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_type_in(dec_type_in), .dec_op_in(dec_op_in),
    .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
    .dec_rd_in(dec_rd_in), .dec_imm_in(dec_imm_in),
    .rf_rs1_out(rf_rs1_out), .rf_rs2_out(rf_rs2_out),
    .rf_rs1_busy_in(rf_rs1_busy_in),
    .rf_rs2_busy_in(rf_rs2_busy_in),
    .rf_rs1_val_in(rf_rs1_val_in), .rf_rs2_val_in(rf_rs2_val_in),
    .rf_rs1_rob_in(rf_rs1_rob_in), .rf_rs2_rob_in(rf_rs2_rob_in),
    .rf_rename_out(rf_rename_out), .rf_rd_out(rf_rd_out),
    .rf_rob_out(rf_rob_out),
    .rob_ready_in(rob_ready_in), .rob_tag_in(rob_tag_in),
    .rob_alloc_out(rob_alloc_out), .rob_type_out(rob_type_out),
    .rob_dest_out(rob_dest_out),
    .rob_q1_out(rob_q1_out), .rob_q2_out(rob_q2_out),
    .rob_q1_rdy_in(rob_q1_rdy_in), .rob_q2_rdy_in(rob_q2_rdy_in),
    .rob_q1_val_in(rob_q1_val_in), .rob_q2_val_in(rob_q2_val_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in),
    .cdb_val_in(cdb_val_in),
    .flush_in(flush_in), .rs_ready_in(rs_ready_in),
    .rs_valid_out(rs_valid_out), .rs_op_out(rs_op_out),
    .rs_vj_out(rs_vj_out), .rs_vk_out(rs_vk_out),
    .rs_qj_out(rs_qj_out), .rs_qk_out(rs_qk_out),
    .rs_qj_busy_out(rs_qj_busy_out),
    .rs_qk_busy_out(rs_qk_busy_out),
    .rs_a_out(rs_a_out), .rs_tag_out(rs_tag_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat(input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [4:0] rd,
                      input logic [31:0] imm);
    dec_valid_in = 1'b1;
    dec_type_in  = 3'd1;
    dec_op_in    = 6'h21;
    dec_rs1_in   = rs1;
    dec_rs2_in   = rs2;
    dec_rd_in    = rd;
    dec_imm_in   = imm;
  endtask

  task automatic rf_clear();
    rf_rs1_busy_in = 1'b0; rf_rs2_busy_in = 1'b0;
    rf_rs1_val_in = '0; rf_rs2_val_in = '0;
    rf_rs1_rob_in = '0; rf_rs2_rob_in = '0;
    rob_q1_rdy_in = 1'b0; rob_q2_rdy_in = 1'b0;
    rob_q1_val_in = '0; rob_q2_val_in = '0;
    cdb_valid_in = 1'b0; cdb_tag_in = '0; cdb_val_in = '0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    dec_valid_in = 1'b0; dec_type_in = '0; dec_op_in = '0;
    dec_rs1_in = '0; dec_rs2_in = '0; dec_rd_in = '0;
    dec_imm_in = '0;
    rf_clear();
    rob_ready_in = 1'b1; rob_tag_in = '0;
    flush_in = 1'b0; rs_ready_in = 1'b1;
    #12;
    check("rst_ready", 32'(dec_ready_out), 1);
    check("rst_valid", 32'(rs_valid_out), 0);
    check("rst_alloc", 32'(rob_alloc_out), 0);
    check("rst_rename", 32'(rf_rename_out), 0);
    check("rst_rs1", 32'(rf_rs1_out), 0);
    check("rst_dest", rob_dest_out, 0);
    rst_in = 1'b1;
    step();

    // add x3,x1,x2 into an empty queue
    beat(5'd1, 5'd2, 5'd3, 32'h10);
    rob_tag_in = 4'd4;
    rf_rs1_val_in = 32'd5; rf_rs2_val_in = 32'd7;
    check("empty_noalloc", 32'(rob_alloc_out), 0);
    step();
    dec_valid_in = 1'b0;
    check("n1_valid", 32'(rs_valid_out), 0);
    check("n1_rename", 32'(rf_rename_out), 1);
    check("n1_rd", 32'(rf_rd_out), 3);
    check("n1_rs1", 32'(rf_rs1_out), 1);
    check("n1_rs2", 32'(rf_rs2_out), 2);
    check("n1_robtag", 32'(rf_rob_out), 4);
    check("n1_dest", rob_dest_out, 3);
    check("n1_type", 32'(rob_type_out), 1);
    step();
    check("n2_valid", 32'(rs_valid_out), 1);
    check("n2_vj", rs_vj_out, 5);
    check("n2_vk", rs_vk_out, 7);
    check("n2_qjb", 32'(rs_qj_busy_out), 0);
    check("n2_qkb", 32'(rs_qk_busy_out), 0);
    check("n2_op", 32'(rs_op_out), 32'h21);
    check("n2_a", rs_a_out, 32'h10);
    check("n2_tag", 32'(rs_tag_out), 4);
    step();
    check("n3_pulse", 32'(rs_valid_out), 0);
    check("n3_hold_a", rs_a_out, 32'h10);

    // Fill to DEPTH; a fifth beat must be dropped
    rs_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(5'd1, 5'd2, 5'(10 + i), 32'(100 + i));
      step();
    end
    check("fill_ready", 32'(dec_ready_out), 0);
    beat(5'd1, 5'd2, 5'd14, 32'd104);
    step();
    dec_valid_in = 1'b0;
    check("fill5_ready", 32'(dec_ready_out), 0);
    check("fill_nopulse", 32'(rs_valid_out), 0);
    rs_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rob_tag_in = 4'(i);
      check($sformatf("drain%0d_rd", i), 32'(rf_rd_out), 10 + i);
      step();
      check($sformatf("drain%0d_v", i), 32'(rs_valid_out), 1);
      check($sformatf("drain%0d_a", i), rs_a_out, 100 + i);
      check($sformatf("drain%0d_tag", i), 32'(rs_tag_out), i);
    end
    check("drain_ready", 32'(dec_ready_out), 1);
    step();
    check("drain_end", 32'(rs_valid_out), 0);

    // CDB snoop on rs1, pending tag 0 on rs2
    beat(5'd4, 5'd6, 5'd5, 32'h20);
    step();
    dec_valid_in = 1'b0;
    rf_rs1_busy_in = 1'b1; rf_rs1_rob_in = 4'd2;
    rf_rs2_busy_in = 1'b1; rf_rs2_rob_in = 4'd0;
    cdb_valid_in = 1'b1; cdb_tag_in = 4'd2; cdb_val_in = 32'h55;
    check("q1_tag", 32'(rob_q1_out), 2);
    check("q2_tag", 32'(rob_q2_out), 0);
    step();
    check("cdb_valid", 32'(rs_valid_out), 1);
    check("cdb_vj", rs_vj_out, 32'h55);
    check("cdb_qjb", 32'(rs_qj_busy_out), 0);
    check("pend_qk", 32'(rs_qk_out), 0);
    check("pend_qkb", 32'(rs_qk_busy_out), 1);
    check("pend_vk", rs_vk_out, 0);
    rf_clear();

    // ROB forward on rs1, x0 on rs2 even if busy, rd=x0
    beat(5'd7, 5'd0, 5'd0, 32'h30);
    step();
    dec_valid_in = 1'b0;
    rf_rs1_busy_in = 1'b1; rf_rs1_rob_in = 4'd3;
    rob_q1_rdy_in = 1'b1; rob_q1_val_in = 32'h99;
    rf_rs2_busy_in = 1'b1; rf_rs2_val_in = 32'hAA;
    check("x0_rename", 32'(rf_rename_out), 0);
    check("x0_alloc", 32'(rob_alloc_out), 1);
    step();
    check("rob_vj", rs_vj_out, 32'h99);
    check("rob_qjb", 32'(rs_qj_busy_out), 0);
    check("x0_vk", rs_vk_out, 0);
    check("x0_qkb", 32'(rs_qk_busy_out), 0);
    rf_clear();

    // Flush with 3 queued plus a same-cycle beat
    rs_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(5'd1, 5'd2, 5'd8, 32'(200 + i));
      step();
    end
    beat(5'd1, 5'd2, 5'd9, 32'd203);
    flush_in = 1'b1; rs_ready_in = 1'b1;
    check("flush_noalloc", 32'(rob_alloc_out), 0);
    step();
    flush_in = 1'b0; dec_valid_in = 1'b0;
    check("flush_ready", 32'(dec_ready_out), 1);
    check("flush_valid", 32'(rs_valid_out), 0);
    check("flush_empty", 32'(rob_alloc_out), 0);
    step();
    check("flush_nopulse", 32'(rs_valid_out), 0);

    // Freeze with a full queue
    rs_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(5'd1, 5'd2, 5'd9, 32'(300 + i));
      step();
    end
    dec_valid_in = 1'b0;
    rdy_in = 1'b0; rs_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("frz%0d_alloc", i), 32'(rob_alloc_out), 0);
      step();
      check($sformatf("frz%0d_valid", i), 32'(rs_valid_out), 0);
      check($sformatf("frz%0d_ready", i), 32'(dec_ready_out), 0);
    end
    rdy_in = 1'b1;
    step();
    check("thaw_valid", 32'(rs_valid_out), 1);
    check("thaw_a", rs_a_out, 300);
    rdy_in = 1'b0;
    step();
    check("hold_valid", 32'(rs_valid_out), 1);
    check("hold_a", rs_a_out, 300);

    // Async reset mid-cycle
    rdy_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_valid", 32'(rs_valid_out), 0);
    check("arst_ready", 32'(dec_ready_out), 1);
    check("arst_alloc", 32'(rob_alloc_out), 0);
    check("arst_a", rs_a_out, 0);
    #1;
    rst_in = 1'b1;
    step();
    check("post_valid", 32'(rs_valid_out), 0);
    check("post_alloc", 32'(rob_alloc_out), 0);
    step();
    check("post_nopulse", 32'(rs_valid_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter ROB_W, default 4, ROB tag width.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter OPC_W, default 6, opcode width.
REQ-004 Parameter TYPE_W, default 3, op-type width.
REQ-005 clk_in  input  1  sole clock; all state on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 rdy_in  input  1  global enable; 0 freezes all state.
REQ-008 dec_valid_in  input  1, and dec_ready_out  output  1: decoder handshake.
REQ-009 dec_type_in  input  TYPE_W, dec_op_in  input  OPC_W, dec_rs1_in/dec_rs2_in/dec_rd_in  input  5 each, dec_imm_in  input  32: decoded instruction.
REQ-010 rf_rs1_out/rf_rs2_out  output  5: regfile lookup indices, taken from the queue head.
REQ-011 rf_rs1_busy_in/rf_rs2_busy_in  input  1, rf_rs1_val_in/rf_rs2_val_in  input  32, rf_rs1_rob_in/rf_rs2_rob_in  input  ROB_W: lookup results.
REQ-012 rf_rename_out  output  1, rf_rd_out  output  5, rf_rob_out  output  ROB_W: rename write.
REQ-013 rob_ready_in  input  1 (ROB not full), rob_tag_in  input  ROB_W (next free tag).
REQ-014 rob_alloc_out  output  1, rob_type_out  output  TYPE_W, rob_dest_out  output  32: ROB allocation.
REQ-015 rob_q1_out/rob_q2_out  output  ROB_W: ROB ready-query tags; rob_q1_rdy_in/rob_q2_rdy_in  input  1 and rob_q1_val_in/rob_q2_val_in  input  32: query results.
REQ-016 cdb_valid_in  input  1, cdb_tag_in  input  ROB_W, cdb_val_in  input  32: common data bus.
REQ-017 flush_in  input  1: mispredict flush.
REQ-018 rs_ready_in  input  1: reservation station has a free slot.
REQ-019 rs_valid_out  output  1, rs_op_out  output  OPC_W, rs_vj_out/rs_vk_out  output  32, rs_qj_out/rs_qk_out  output  ROB_W, rs_qj_busy_out/rs_qk_busy_out  output  1, rs_a_out  output  32, rs_tag_out  output  ROB_W: issued entry, all registered.

Function
REQ-020 Queue: circular, DEPTH entries; head/tail pointers wrap modulo DEPTH; count register ranges 0..DEPTH.
REQ-021 Ready: dec_ready_out SHALL equal (count != DEPTH), registered-state derived, independent of dec_valid_in.
REQ-022 Enqueue: occurs on an edge where dec_valid_in & dec_ready_out & rdy_in & !flush_in.
REQ-023 Fire: fire = (count != 0) & rob_ready_in & rs_ready_in & rdy_in & !flush_in; on fire the head pops at the edge.
REQ-024 Same-edge enqueue and fire: count SHALL be unchanged; both pointers advance.
REQ-025 Empty queue: no bypass; minimum latency is 2 cycles (enqueue edge N, fire in cycle N+1, rs_valid_out high in cycle N+2).
REQ-026 Rename and allocate: rob_alloc_out = fire and rf_rename_out = fire & (head rd != 0), both combinational.
REQ-027 rf_rd_out = head rd; rf_rob_out = rob_tag_in; rob_type_out = head type; rob_dest_out = head rd zero-extended to 32 bits.
REQ-028 Operand resolution for each source, in priority order:
- index 0 -> value 0, not busy;
- regfile not busy -> regfile value;
- busy and ROB query ready -> ROB value;
- busy and cdb_valid_in with cdb_tag_in == regfile tag -> cdb_val_in;
- otherwise busy, q = regfile tag, v = 0.
REQ-029 rob_q1_out/rob_q2_out SHALL equal rf_rs1_rob_in/rf_rs2_rob_in.
REQ-030 Issue register, on a fire edge: rs_valid_out <= 1; load op, resolved operands, busy flags and imm to rs_a_out; rs_tag_out <= rob_tag_in.
REQ-031 Issue register, on a non-fire edge with rdy_in=1: rs_valid_out <= 0 and the data fields hold; rs_valid_out is therefore a one-cycle pulse per issue.
REQ-032 Busy flags, not tag 0, mark pending operands; tag 0 is a legal ROB tag.
REQ-033 Flush edge (rdy_in=1): count <= 0, head <= tail <= 0, rs_valid_out <= 0; a decoder beat presented in that cycle is dropped.
REQ-034 rdy_in=0: no enqueue, no fire, rs_valid_out held, all registers held.

Reset
REQ-035 rst_in low SHALL immediately clear count, pointers and all registered outputs to 0, independent of clk_in.
REQ-036 After reset: dec_ready_out=1; all combinational outputs are 0.
REQ-037 Reset asserted mid-operation SHALL discard all queued entries and any pending issue.

Verification
REQ-038 Empty queue: enqueue add x3,x1,x2 with x1/x2 not busy (values 5, 7) at edge N -> rs_valid_out=1 in N+2 with vj=5, vk=7, qj_busy=qk_busy=0; rf_rename_out=1, rf_rd_out=3 in N+1.
REQ-039 Fill: enqueue DEPTH=4 beats with rs_ready_in=0 -> dec_ready_out=0; a fifth beat is ignored; raising rs_ready_in issues 4 pulses in FIFO order.
REQ-040 Operand sources: rs1 busy on tag 2 with the ROB not ready and cdb_valid_in with tag 2, value 0x55 in the fire cycle -> vj=0x55, qj_busy=0; rs2 busy on tag 0, not ready, no CDB -> qk=0, qk_busy=1.
REQ-041 Flush with 3 queued entries plus a simultaneous decoder beat -> count=0 next cycle, no rs_valid_out pulse, dec_ready_out=1.
REQ-042 rdy_in held low 3 cycles with a full queue and rs_ready_in=1 -> no state change; async reset pulse mid-cycle -> outputs 0 before the next edge.
